// File: rtl/serial_output_pkg.sv
// Shared types and constants for the serial_output UART transmitter.
// SERIAL_OUTPUT_PARITY_EN adds an even-parity bit after the payload.
package serial_output_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
`ifdef SERIAL_OUTPUT_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef SERIAL_OUTPUT_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int divisor);
        return (1 + DATA_BITS + PARITY_BITS + STOP_BITS) * divisor;
    endfunction

endpackage

// File: rtl/serial_output_baud_counter.sv
// Bit-period down-counter: load starts a fresh DIVISOR-cycle period,
// bit_done marks the final cycle of the period while the line is active.
module serial_output_baud_counter #(
    parameter int DIVISOR = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic active,
    output logic bit_done
);

    localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on demand, otherwise count down and hold at zero (never wraps).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign bit_done = active && (cnt == '0);

endmodule

// File: rtl/serial_output.sv
// UART transmitter: accepts one byte via stb/ack handshake and shifts out
// start, 8 data bits LSB first, optional even parity, and one stop bit.
// Optional feature macro: SERIAL_OUTPUT_PARITY_EN.
module serial_output
    import serial_output_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic        in1_stb,
    output logic        in1_ack,
    output logic        tx
);

    localparam int DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;

    generate
        if (DIVISOR < 2) begin : g_divisor_check
            $error("serial_output: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
        end
    endgenerate

    state_t      state, state_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  data_q;
    logic        tx_q, tx_d;
    logic        bit_done, reload, active;

    // Only the low byte is transmitted.
    logic unused_hi;
    assign unused_hi = ^in1[31:8];

    serial_output_baud_counter #(.DIVISOR(DIVISOR)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (reload),
        .active   (active),
        .bit_done (bit_done)
    );

    assign active = (state != IDLE) && (state != ACCEPT);

    // Next-state, bit index, counter reload and next line level.
    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        reload    = 1'b0;
        tx_d      = 1'b1;
        case (state)
            IDLE:   if (in1_stb) state_d = ACCEPT;
            ACCEPT: begin
                state_d   = START;
                bit_idx_d = 3'd0;
                reload    = 1'b1;
            end
            START:  if (bit_done) begin
                state_d = DATA;
                reload  = 1'b1;
            end
            DATA:   if (bit_done) begin
                reload = 1'b1;
                if (bit_idx == 3'(DATA_BITS - 1))
`ifdef SERIAL_OUTPUT_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                else
                    bit_idx_d = bit_idx + 3'd1;
            end
`ifdef SERIAL_OUTPUT_PARITY_EN
            PARITY: if (bit_done) begin
                state_d = STOP;
                reload  = 1'b1;
            end
`endif
            STOP:   if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_q[bit_idx_d];
`ifdef SERIAL_OUTPUT_PARITY_EN
            PARITY: tx_d = ^data_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, bit index, captured payload and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_d;
            bit_idx <= bit_idx_d;
            tx_q    <= tx_d;
            if (state == ACCEPT)
                data_q <= in1[7:0];
        end
    end

    assign in1_ack = (state == ACCEPT);
    assign tx      = tx_q;

endmodule

// File: doc/serial_output.md
SERIAL_OUTPUT -- requirements
Module: serial_output

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial line bit rate in bits/s.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in1  input  32  word to transmit; bits 7:0 are the payload, bits 31:8 are ignored.
REQ-006 Port in1_stb  input  1  producer asserts it while in1 is valid; producer holds it and in1 stable until ack.
REQ-007 Port in1_ack  output  1  one-cycle acceptance pulse.
REQ-008 Port tx  output  1  UART serial line; idle high.

Function
REQ-009 The block SHALL derive DIVISOR = CLOCK_FREQUENCY / BAUD_RATE (integer, truncated); every transmitted bit SHALL last exactly DIVISOR clk cycles.
REQ-010 States SHALL be IDLE, ACCEPT, START, DATA, PARITY (macro only), STOP.
REQ-011 IDLE: tx=1 and in1_ack=0; on a cycle with in1_stb=1 the block SHALL go to ACCEPT.
REQ-012 ACCEPT: in1_ack=1 for exactly this one cycle; in1[7:0] SHALL be captured on the edge ending it; next state is START.
REQ-013 START: tx=0 for DIVISOR cycles, then DATA.
REQ-014 DATA: payload bits SHALL be sent LSB first, bit index 0..7, DIVISOR cycles each; after bit 7 go to PARITY if enabled, else STOP.
REQ-015 STOP: tx=1 for DIVISOR cycles, then IDLE.
REQ-016 First start-bit cycle SHALL be 2 cycles after the first cycle in1_stb is high in IDLE.
REQ-017 Frame length SHALL be 10*DIVISOR cycles (11*DIVISOR with parity); back-to-back words SHALL have at least one IDLE cycle between STOP end and the next ACCEPT.
REQ-018 in1_stb asserted during an active frame SHALL be ignored (no ack) until IDLE is reached.
REQ-019 in1_ack SHALL never be high outside ACCEPT.
REQ-020 The bit-period counter SHALL reload to DIVISOR-1 on every state or bit change and SHALL not wrap mid-bit.
REQ-021 tx SHALL be driven from a register (glitch-free).

Reset
REQ-022 While rst=1: state=IDLE, tx=1, in1_ack=0, bit index=0, counter=0, captured data=0.
REQ-023 Reset asserted mid-frame SHALL drive tx high immediately (asynchronously) and abandon the frame; no ack is re-issued for the lost word.
REQ-024 After rst deasserts, the first accept SHALL follow REQ-011 unchanged.

Configuration
REQ-025 Macro SERIAL_OUTPUT_PARITY_EN: when defined, the block SHALL insert a PARITY bit after DATA equal to the XOR of the 8 payload bits (even parity); when undefined, PARITY state and logic SHALL not exist and DATA goes directly to STOP.

Structure
REQ-026 Package serial_output_pkg SHALL hold the state enum typedef and constants DATA_BITS=8, STOP_BITS=1, and the frame-length function.
REQ-027 Sub-module serial_output_baud_counter SHALL implement the reloadable DIVISOR down-counter with a one-cycle bit_done output.
REQ-028 Elaboration SHALL fail if DIVISOR < 2.

Verification (CLOCK_FREQUENCY=50000000, BAUD_RATE=115200, DIVISOR=434)
REQ-029 in1=0x00000055, stb held -> ack pulses once 1 cycle after stb; tx: 0 for 434 cycles, then 1,0,1,0,1,0,1,0 at 434 cycles each, then 1 for 434; total 4340 cycles.
REQ-030 in1=0xFFFFFFA3 -> serial payload 0xA3 (LSB first 1,1,0,0,0,1,0,1); upper bits have no effect.
REQ-031 Two words 0x41, 0x42 with stb held continuously -> exactly two ack pulses, second ack no earlier than 4341 cycles after the first; both frames intact.
REQ-032 rst pulsed at cycle 2000 of a frame -> tx=1 in the same cycle, in1_ack=0, next word after release transmitted correctly.
REQ-033 SERIAL_OUTPUT_PARITY_EN defined, in1=0x07 -> parity bit 1 after bit 7, frame 4774 cycles; in1=0x03 -> parity bit 0.
REQ-034 stb never asserted for 10000 cycles after reset -> tx constant 1, in1_ack constant 0.
